// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register.
// Holds decoder control, register addresses and operands for one Execute slot.
// Supports stall (hold), flush (bubble insertion) and a per-slot valid bit.
// Write enables are gated so that an empty slot can never change architectural state.
module id_ex_pipe_reg #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 4,
  parameter int ALUCTL_W = 2
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                StallE,
  input  logic                FlushE,
  input  logic                ValidD,
  input  logic [3:0]          CondD,
  input  logic [1:0]          FlagWD,
  input  logic                PCSD,
  input  logic                RegWD,
  input  logic                MemWD,
  input  logic                BranchD,
  input  logic                MemtoRegD,
  input  logic                ALUSrcD,
  input  logic [ALUCTL_W-1:0] ALUControlD,
  input  logic [RADDR_W-1:0]  RA1D,
  input  logic [RADDR_W-1:0]  RA2D,
  input  logic [RADDR_W-1:0]  WA3D,
  input  logic [DATA_W-1:0]   RD1D,
  input  logic [DATA_W-1:0]   RD2D,
  input  logic [DATA_W-1:0]   ExtImmD,
  output logic                ValidE,
  output logic [3:0]          CondE,
  output logic [1:0]          FlagWE,
  output logic                PCSE,
  output logic                RegWE,
  output logic                MemWE,
  output logic                BranchE,
  output logic                MemtoRegE,
  output logic                ALUSrcE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic [RADDR_W-1:0]  RA1E,
  output logic [RADDR_W-1:0]  RA2E,
  output logic [RADDR_W-1:0]  WA3E,
  output logic [DATA_W-1:0]   RD1E,
  output logic [DATA_W-1:0]   RD2E,
  output logic [DATA_W-1:0]   ExtImmE
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  // Condition code "always": a flushed slot presents a harmless no-op to condlogic.
  localparam logic [3:0] COND_AL = 4'hE;

  slot_state_t           state_p1, state_n;
  logic [3:0]            cond_p1;
  logic [1:0]            flagw_p1;
  logic                  pcs_p1, regw_p1, memw_p1, branch_p1;
  logic                  memtoreg_p1, alusrc_p1;
  logic [ALUCTL_W-1:0]   aluctl_p1;
  logic [RADDR_W-1:0]    ra1_p1, ra2_p1, wa3_p1;
  logic [DATA_W-1:0]     rd1_p1, rd2_p1, extimm_p1;

  // Slot occupancy register: EMPTY after reset.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_p1 <= EMPTY;
    else        state_p1 <= state_n;
  end

  // Next occupancy: flush empties, stall holds, load follows ValidD.
  always_comb begin
    state_n = state_p1;
    if (FlushE)       state_n = EMPTY;
    else if (!StallE) state_n = ValidD ? FULL : EMPTY;
  end

  // Control fields: bubble on flush, hold on stall, otherwise load with enables qualified by ValidD.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cond_p1     <= 4'h0;
      flagw_p1    <= 2'b00;
      pcs_p1      <= 1'b0;
      regw_p1     <= 1'b0;
      memw_p1     <= 1'b0;
      branch_p1   <= 1'b0;
      memtoreg_p1 <= 1'b0;
      alusrc_p1   <= 1'b0;
      aluctl_p1   <= '0;
    end else if (FlushE) begin
      cond_p1     <= COND_AL;
      flagw_p1    <= 2'b00;
      pcs_p1      <= 1'b0;
      regw_p1     <= 1'b0;
      memw_p1     <= 1'b0;
      branch_p1   <= 1'b0;
      memtoreg_p1 <= 1'b0;
      alusrc_p1   <= 1'b0;
      aluctl_p1   <= '0;
    end else if (!StallE) begin
      cond_p1     <= CondD;
      flagw_p1    <= FlagWD & {2{ValidD}};
      pcs_p1      <= PCSD & ValidD;
      regw_p1     <= RegWD & ValidD;
      memw_p1     <= MemWD & ValidD;
      branch_p1   <= BranchD & ValidD;
      memtoreg_p1 <= MemtoRegD;
      alusrc_p1   <= ALUSrcD;
      aluctl_p1   <= ALUControlD;
    end
  end

  // Address and operand fields: zeroed on reset and flush, held on stall, otherwise loaded.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ra1_p1    <= '0;
      ra2_p1    <= '0;
      wa3_p1    <= '0;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      extimm_p1 <= '0;
    end else if (FlushE) begin
      ra1_p1    <= '0;
      ra2_p1    <= '0;
      wa3_p1    <= '0;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      extimm_p1 <= '0;
    end else if (!StallE) begin
      ra1_p1    <= RA1D;
      ra2_p1    <= RA2D;
      wa3_p1    <= WA3D;
      rd1_p1    <= RD1D;
      rd2_p1    <= RD2D;
      extimm_p1 <= ExtImmD;
    end
  end

  // Outputs come straight from registers; enables are additionally masked by the valid bit.
  assign ValidE      = (state_p1 == FULL);
  assign CondE       = cond_p1;
  assign FlagWE      = flagw_p1 & {2{ValidE}};
  assign PCSE        = pcs_p1 & ValidE;
  assign RegWE       = regw_p1 & ValidE;
  assign MemWE       = memw_p1 & ValidE;
  assign BranchE     = branch_p1 & ValidE;
  assign MemtoRegE   = memtoreg_p1;
  assign ALUSrcE     = alusrc_p1;
  assign ALUControlE = aluctl_p1;
  assign RA1E        = ra1_p1;
  assign RA2E        = ra2_p1;
  assign WA3E        = wa3_p1;
  assign RD1E        = rd1_p1;
  assign RD2E        = rd2_p1;
  assign ExtImmE     = extimm_p1;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed testbench for the decode-to-execute pipeline register.
module tb_id_ex_pipe_reg;

  logic        CLK, Reset, StallE, FlushE, ValidD;
  logic [3:0]  CondD;
  logic [1:0]  FlagWD;
  logic        PCSD, RegWD, MemWD, BranchD, MemtoRegD, ALUSrcD;
  logic [1:0]  ALUControlD;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic [31:0] RD1D, RD2D, ExtImmD;

  logic        ValidE;
  logic [3:0]  CondE;
  logic [1:0]  FlagWE;
  logic        PCSE, RegWE, MemWE, BranchE, MemtoRegE, ALUSrcE;
  logic [1:0]  ALUControlE;
  logic [3:0]  RA1E, RA2E, WA3E;
  logic [31:0] RD1E, RD2E, ExtImmE;

  int checks = 0;
  int errors = 0;

  id_ex_pipe_reg #(.DATA_W(32), .RADDR_W(4), .ALUCTL_W(2)) dut (
    .CLK(CLK), .Reset(Reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .CondD(CondD), .FlagWD(FlagWD), .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD),
    .BranchD(BranchD), .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD),
    .ValidE(ValidE), .CondE(CondE), .FlagWE(FlagWE), .PCSE(PCSE), .RegWE(RegWE),
    .MemWE(MemWE), .BranchE(BranchE), .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ValidE"}, 32'(ValidE), 32'd0);
    chk({tag, ".CondE"},  32'(CondE),  32'd0);
    chk({tag, ".enables"}, 32'({FlagWE, PCSE, RegWE, MemWE, BranchE}), 32'd0);
    chk({tag, ".misc"}, 32'({MemtoRegE, ALUSrcE, ALUControlE}), 32'd0);
    chk({tag, ".addr"}, 32'({RA1E, RA2E, WA3E}), 32'd0);
    chk({tag, ".RD1E"}, RD1E, 32'd0);
    chk({tag, ".RD2E"}, RD2E, 32'd0);
    chk({tag, ".ExtImmE"}, ExtImmE, 32'd0);
  endtask

  initial begin
    Reset = 1'b0; StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b0;
    CondD = 4'h0; FlagWD = 2'b00; PCSD = 1'b0; RegWD = 1'b0; MemWD = 1'b0;
    BranchD = 1'b0; MemtoRegD = 1'b0; ALUSrcD = 1'b0; ALUControlD = 2'b00;
    RA1D = 4'h0; RA2D = 4'h0; WA3D = 4'h0; RD1D = 32'h0; RD2D = 32'h0; ExtImmD = 32'h0;

    // Reset state
    @(negedge CLK);
    chk_all_zero("reset");
    Reset = 1'b1;
    step();
    chk("post_release_empty", 32'(ValidE), 32'd0);

    // Basic load
    ValidD = 1'b1; CondD = 4'h0; RegWD = 1'b1; WA3D = 4'd7; RD1D = 32'hDEADBEEF;
    RA1D = 4'd3; RA2D = 4'd9; RD2D = 32'hA5A5_0001; ExtImmD = 32'h0000_00FF;
    ALUSrcD = 1'b1; ALUControlD = 2'b10; MemtoRegD = 1'b1;
    step();
    chk("load.ValidE", 32'(ValidE), 32'd1);
    chk("load.CondE",  32'(CondE),  32'h0);
    chk("load.RegWE",  32'(RegWE),  32'd1);
    chk("load.WA3E",   32'(WA3E),   32'd7);
    chk("load.RD1E",   RD1E,        32'hDEADBEEF);
    chk("load.RD2E",   RD2E,        32'hA5A5_0001);
    chk("load.ExtImmE", ExtImmE,    32'h0000_00FF);
    chk("load.addr",   32'({RA1E, RA2E}), 32'h39);
    chk("load.misc",   32'({MemtoRegE, ALUSrcE, ALUControlE}), 32'hE);

    // Stall for three edges with changed inputs
    StallE = 1'b1; RD1D = 32'h1234;
    #1;
    chk("no_comb_path.RD1E", RD1E, 32'hDEADBEEF);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.RD1E",   RD1E,        32'hDEADBEEF);
      chk("stall.RegWE",  32'(RegWE),  32'd1);
      chk("stall.ValidE", 32'(ValidE), 32'd1);
    end
    StallE = 1'b0;
    step();
    chk("stall_release.RD1E", RD1E, 32'h1234);

    // Flush with simultaneous stall
    MemWD = 1'b1; FlagWD = 2'b11; CondD = 4'h3; RD1D = 32'h5555_AAAA;
    step();
    chk("flush_pre.MemWE",  32'(MemWE),  32'd1);
    chk("flush_pre.FlagWE", 32'(FlagWE), 32'd3);
    FlushE = 1'b1; StallE = 1'b1;
    step();
    chk("flush.ValidE", 32'(ValidE), 32'd0);
    chk("flush.MemWE",  32'(MemWE),  32'd0);
    chk("flush.RegWE",  32'(RegWE),  32'd0);
    chk("flush.FlagWE", 32'(FlagWE), 32'd0);
    chk("flush.CondE",  32'(CondE),  32'hE);
    chk("flush.RD1E",   RD1E,        32'd0);
    chk("flush.WA3E",   32'(WA3E),   32'd0);
    chk("flush.ExtImmE", ExtImmE,    32'd0);

    // Stall while empty keeps the slot empty
    FlushE = 1'b0; StallE = 1'b1;
    step();
    chk("stall_empty.ValidE", 32'(ValidE), 32'd0);
    chk("stall_empty.CondE",  32'(CondE),  32'hE);

    // Invalid slot: enables suppressed, other fields loaded
    StallE = 1'b0; ValidD = 1'b0; RegWD = 1'b1; MemWD = 1'b1; FlagWD = 2'b11;
    PCSD = 1'b1; BranchD = 1'b1; MemtoRegD = 1'b1; CondD = 4'h5; RD2D = 32'h55;
    step();
    chk("invalid.ValidE",  32'(ValidE),  32'd0);
    chk("invalid.RegWE",   32'(RegWE),   32'd0);
    chk("invalid.MemWE",   32'(MemWE),   32'd0);
    chk("invalid.FlagWE",  32'(FlagWE),  32'd0);
    chk("invalid.PCSE",    32'(PCSE),    32'd0);
    chk("invalid.BranchE", 32'(BranchE), 32'd0);
    chk("invalid.MemtoRegE", 32'(MemtoRegE), 32'd1);
    chk("invalid.CondE",   32'(CondE),   32'h5);
    chk("invalid.RD2E",    RD2E,         32'h55);

    // Back-to-back loads
    ValidD = 1'b1; PCSD = 1'b0; BranchD = 1'b0; MemWD = 1'b0; FlagWD = 2'b00;
    for (int i = 0; i < 8; i++) begin
      WA3D = 4'(i);
      step();
      chk("b2b.WA3E",   32'(WA3E),   32'(i));
      chk("b2b.ValidE", 32'(ValidE), 32'd1);
    end

    // Asynchronous reset mid-cycle while full
    chk("areset_pre.ValidE", 32'(ValidE), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk_all_zero("areset");
    @(negedge CLK);
    Reset = 1'b1; StallE = 1'b1; ValidD = 1'b1;
    step();
    chk("release_stall.ValidE", 32'(ValidE), 32'd0);
    StallE = 1'b0;
    step();
    chk("release_load.ValidE", 32'(ValidE), 32'd1);
    chk("release_load.RegWE",  32'(RegWE),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
